rms_norm_scale: RTL and testbench

- Sits directly downstream of the RMS sum stage.
- Consumes its 144-bit stream. Each beat is {8 lanes x signed Q4.12 elements, 16-bit mean-square}.
- Computes rstd = 1/sqrt(mean-square) once per token, multiplies every element of the token by rstd, and emits the normalized 8-lane stream with TLAST on the token's final beat.

---
 rtl/rms_norm_scale.sv | 166 ++++++++++++++++
 tb/tb_rms_norm_scale.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rms_norm_scale.sv
// RMS-norm scaling stage: derives rstd = 1/sqrt(mean-square) once per token from a LUT,
// then multiplies every element of the token by rstd in a 2-stage stallable pipeline.
module rms_norm_scale #(
  parameter int unsigned BEATS_PER_TOKEN = 96,
  parameter int unsigned LANES           = 8
) (
  input  logic                  aclk,
  input  logic                  arst,
  input  logic [16*LANES+15:0]  S_AXIS_TDATA,
  input  logic                  S_AXIS_TVALID,
  output logic                  S_AXIS_TREADY,
  output logic [16*LANES-1:0]   M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic                  M_AXIS_TLAST
);

  localparam int unsigned CntW = (BEATS_PER_TOKEN > 1) ? $clog2(BEATS_PER_TOKEN) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(BEATS_PER_TOKEN - 1);

  typedef enum logic [2:0] {StIdle, StCalc0, StCalc1, StCalc2, StScale} state_e;

  // round(32768/sqrt(i)) == (floor(sqrt(2^32/i)) + 1) / 2, evaluated at elaboration.
  function automatic logic [15:0] lut_entry(input int unsigned i);
    longint unsigned q, lo, hi, mid;
    if (i < 16) return 16'd0;
    q  = 64'd4294967296 / 64'(i);
    lo = 64'd0;
    hi = 64'd65536;
    for (int k = 0; k < 20; k++) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= q) lo = mid;
      else hi = mid;
    end
    return 16'((lo + 64'd1) / 2);
  endfunction

  logic [15:0] lut_rom [64];
  for (genvar g = 0; g < 64; g++) begin : g_lut
    localparam logic [15:0] Val = lut_entry(g);
    assign lut_rom[g] = Val;
  end

  state_e          state_q;
  logic [15:0]     ms_q, lut_q, rstd_q;
  logic [5:0]      idx_q;
  logic [2:0]      shift_q;
  logic            zflag_q;
  logic [CntW-1:0] beat_cnt_q;

  logic            pipe_advance, s_accept;
  assign pipe_advance  = !M_AXIS_TVALID | M_AXIS_TREADY;
  assign S_AXIS_TREADY = (state_q == StScale) & pipe_advance;
  assign s_accept      = S_AXIS_TVALID & S_AXIS_TREADY;

  // Normalize: smallest even left shift that puts a one into the top two bits.
  logic [2:0]  norm_s;
  logic [15:0] norm_val, norm_tmp;
  always_comb begin
    norm_s   = 3'd7;
    norm_val = '0;
    norm_tmp = '0;
    for (int s = 7; s >= 0; s--) begin
      norm_tmp = ms_q << (2 * s);
      if (norm_tmp[15:14] != 2'b00) begin
        norm_s   = 3'(s);
        norm_val = norm_tmp;
      end
    end
  end

  logic [18:0] rstd_wide;
  logic [15:0] rstd_next;
  always_comb begin
    if (shift_q <= 3'd4) rstd_wide = {3'b000, lut_q} >> (3'd4 - shift_q);
    else                 rstd_wide = {3'b000, lut_q} << (shift_q - 3'd4);
    if (zflag_q || (rstd_wide[18:16] != 3'b000)) rstd_next = 16'hFFFF;
    else                                         rstd_next = rstd_wide[15:0];
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      state_q    <= StIdle;
      ms_q       <= '0;
      lut_q      <= '0;
      rstd_q     <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      zflag_q    <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (S_AXIS_TVALID) begin
            ms_q    <= S_AXIS_TDATA[15:0];
            state_q <= StCalc0;
          end
        end
        StCalc0: begin
          zflag_q <= (ms_q == 16'd0);
          shift_q <= norm_s;
          idx_q   <= norm_val[15:10];
          state_q <= StCalc1;
        end
        StCalc1: begin
          lut_q   <= lut_rom[idx_q];
          state_q <= StCalc2;
        end
        StCalc2: begin
          rstd_q  <= rstd_next;
          state_q <= StScale;
        end
        StScale: begin
          if (s_accept) begin
            if (beat_cnt_q == LastBeat) begin
              beat_cnt_q <= '0;
              state_q    <= StIdle;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic signed [32:0] prod_d [LANES];
  logic signed [32:0] prod_q [LANES];
  logic signed [32:0] shr    [LANES];
  logic [16*LANES-1:0] y_d;
  logic                v1_q, last1_q;

  always_comb begin
    y_d = '0;
    for (int i = 0; i < LANES; i++) begin
      prod_d[i] = $signed({{17{S_AXIS_TDATA[16*i+31]}}, S_AXIS_TDATA[16*i+16 +: 16]}) *
                  $signed({17'b0, rstd_q});
      shr[i] = prod_q[i] >>> 12;
      if (shr[i] > 33'sd32767)       y_d[16*i +: 16] = 16'h7FFF;
      else if (shr[i] < -33'sd32768) y_d[16*i +: 16] = 16'h8000;
      else                           y_d[16*i +: 16] = shr[i][15:0];
    end
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      v1_q          <= 1'b0;
      last1_q       <= 1'b0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TLAST  <= 1'b0;
      M_AXIS_TDATA  <= '0;
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
    end else if (pipe_advance) begin
      v1_q    <= s_accept;
      last1_q <= s_accept & (beat_cnt_q == LastBeat);
      if (s_accept) begin
        for (int i = 0; i < LANES; i++) prod_q[i] <= prod_d[i];
      end
      M_AXIS_TVALID <= v1_q;
      M_AXIS_TLAST  <= v1_q & last1_q;
      if (v1_q) M_AXIS_TDATA <= y_d;
    end
  end

endmodule

// File: tb/tb_rms_norm_scale.sv
// Bench for rms_norm_scale: table-driven tokens plus random-backpressure and mid-token reset
// sequences, all checked through an expected-beat scoreboard.
module tb_rms_norm_scale;
  localparam int unsigned BEATS = 96;
  localparam int unsigned LANES = 8;

  logic         aclk = 1'b0;
  logic         arst;
  logic [143:0] S_AXIS_TDATA;
  logic         S_AXIS_TVALID;
  logic         S_AXIS_TREADY;
  logic [127:0] M_AXIS_TDATA;
  logic         M_AXIS_TVALID;
  logic         M_AXIS_TREADY;
  logic         M_AXIS_TLAST;

  rms_norm_scale #(.BEATS_PER_TOKEN(BEATS), .LANES(LANES)) dut (
    .aclk          (aclk),
    .arst          (arst),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .M_AXIS_TLAST  (M_AXIS_TLAST)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [15:0]  ms;
    logic [127:0] lanes;
    logic [127:0] exp;
  } vec_t;

  typedef struct packed {
    logic         last;
    logic [127:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   tlast_cnt = 0;
  int   cyc = 0;
  bit   mon_en = 0;
  bit   rand_rdy = 0;
  bit   lat_arm = 0;
  int   t_valid = -1, t_ready = -1, t_out = -1;

  task automatic check(input bit ok, input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [15:0] model_rstd(input logic [15:0] ms);
    logic [15:0] sh;
    int          s, lut;
    longint      r;
    if (ms == 16'd0) return 16'hFFFF;
    s  = 0;
    sh = ms;
    while (sh[15:14] == 2'b00) begin
      s++;
      sh = ms << (2 * s);
    end
    lut = $rtoi(32768.0 / $sqrt(real'(sh[15:10])) + 0.5);
    if (s <= 4) r = longint'(lut) >> (4 - s);
    else        r = longint'(lut) << (s - 4);
    return (r > 65535) ? 16'hFFFF : 16'(r);
  endfunction

  function automatic logic [127:0] model_beat(input logic [127:0] x, input logic [15:0] rstd);
    logic [127:0] y;
    longint       p;
    y = '0;
    for (int i = 0; i < 8; i++) begin
      p = longint'($signed(x[16*i +: 16])) * longint'(rstd);
      p = p >>> 12;
      if (p > 32767)       y[16*i +: 16] = 16'h7FFF;
      else if (p < -32768) y[16*i +: 16] = 16'h8000;
      else                 y[16*i +: 16] = 16'(p);
    end
    return y;
  endfunction

  task automatic send_beat(input logic [127:0] el, input logic [15:0] msf,
                           input logic [127:0] exp, input logic last);
    int n = 0;
    bit took = 0;
    S_AXIS_TDATA  = {el, msf};
    S_AXIS_TVALID = 1'b1;
    while (!took && n < 300) begin
      @(negedge aclk);
      if (S_AXIS_TREADY) begin
        exp_q.push_back('{last: last, data: exp});
        took = 1;
      end
      @(posedge aclk);
      #1;
      n++;
    end
    if (!took) check(took, "accept_timeout", 128'(n), 128'd300);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge aclk);
      n++;
    end
    repeat (4) @(posedge aclk);
    #1;
    check(exp_q.size() == 0, "drain_beats_left", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic reset_checks(input string tag);
    check(S_AXIS_TREADY == 1'b0, {tag, "_s_tready"}, 128'(S_AXIS_TREADY), 128'd0);
    check(M_AXIS_TVALID == 1'b0, {tag, "_m_tvalid"}, 128'(M_AXIS_TVALID), 128'd0);
    check(M_AXIS_TLAST == 1'b0, {tag, "_m_tlast"}, 128'(M_AXIS_TLAST), 128'd0);
    check(M_AXIS_TDATA == 128'd0, {tag, "_m_tdata"}, M_AXIS_TDATA, 128'd0);
  endtask

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  initial begin
    M_AXIS_TREADY = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      M_AXIS_TREADY = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard pop, stall stability, TLAST count, first-token latency.
  initial begin
    bit           stall_prev = 0;
    logic [127:0] held_data = '0;
    logic         held_last = 1'b0;
    exp_t         item;
    forever begin
      @(negedge aclk);
      if (lat_arm) begin
        if (t_valid < 0 && S_AXIS_TVALID) t_valid = cyc;
        if (t_ready < 0 && S_AXIS_TREADY) t_ready = cyc;
        if (t_out < 0 && M_AXIS_TVALID)   t_out = cyc;
      end
      if (!arst && mon_en) begin
        if (stall_prev) begin
          check(M_AXIS_TVALID && M_AXIS_TDATA == held_data && M_AXIS_TLAST == held_last,
                "stall_hold", {M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA[125:0]},
                {1'b1, held_last, held_data[125:0]});
        end
        if (M_AXIS_TVALID && !M_AXIS_TREADY)
          check(S_AXIS_TREADY == 1'b0, "stall_s_tready", 128'(S_AXIS_TREADY), 128'd0);
        if (M_AXIS_TVALID && M_AXIS_TREADY) begin
          if (M_AXIS_TLAST) tlast_cnt++;
          check(exp_q.size() != 0, "unexpected_output", M_AXIS_TDATA, 128'd0);
          if (exp_q.size() != 0) begin
            item = exp_q.pop_front();
            check(M_AXIS_TDATA == item.data, "beat_data", M_AXIS_TDATA, item.data);
            check(M_AXIS_TLAST == item.last, "beat_last", 128'(M_AXIS_TLAST), 128'(item.last));
          end
        end
        stall_prev = M_AXIS_TVALID && !M_AXIS_TREADY;
        held_data  = M_AXIS_TDATA;
        held_last  = M_AXIS_TLAST;
      end else begin
        stall_prev = 0;
      end
    end
  end

  initial begin
    vec_t         vecs[6];
    logic [127:0] x;
    logic [15:0]  rs;
    logic [15:0]  ms_list[3];
    int           tl0;

    vecs[0] = '{ms: 16'h0100, lanes: {8{16'h1000}}, exp: {8{16'h1000}}};
    vecs[1] = '{ms: 16'h0400,
                lanes: {16'h1234, 16'hFFFF, 16'h0FFF, 16'h8000,
                        16'h7FFF, 16'h0001, 16'hE000, 16'h2000},
                exp:   {16'h091A, 16'hFFFF, 16'h07FF, 16'hC000,
                        16'h3FFF, 16'h0000, 16'hF000, 16'h1000}};
    vecs[2] = '{ms: 16'h0000,
                lanes: {16'h0800, 16'hFFF0, 16'h0010, 16'hFFFF,
                        16'h0001, 16'h0000, 16'h8000, 16'h7FFF},
                exp:   {16'h7FFF, 16'hFF00, 16'h00FF, 16'hFFF0,
                        16'h000F, 16'h0000, 16'h8000, 16'h7FFF}};
    vecs[3] = '{ms: 16'h0300,
                lanes: {2{16'h0000, 16'h2000, 16'hF000, 16'h1000}},
                exp:   {2{16'h0000, 16'h127A, 16'hF6C3, 16'h093D}}};
    vecs[4] = '{ms: 16'h0001,
                lanes: {2{16'h0000, 16'hFFFF, 16'h1000, 16'h0001}},
                exp:   {2{16'h0000, 16'hFFF0, 16'h7FFF, 16'h000F}}};
    vecs[5] = '{ms: 16'hFFFF, lanes: {8{16'h1000}}, exp: {8{16'h0102}}};

    arst          = 1'b1;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TDATA  = '0;
    repeat (3) @(posedge aclk);
    #1;
    reset_checks("reset");
    arst    = 1'b0;
    mon_en  = 1;
    lat_arm = 1;

    // Table tokens; mean-square field is junk on every beat but the first.
    for (int v = 0; v < 6; v++) begin
      tl0 = tlast_cnt;
      for (int b = 0; b < BEATS; b++)
        send_beat(vecs[v].lanes, (b == 0) ? vecs[v].ms : 16'($urandom), vecs[v].exp,
                  b == BEATS - 1);
      S_AXIS_TVALID = 1'b0;
      wait_drain();
      check(tlast_cnt - tl0 == 1, "table_tlast_count", 128'(tlast_cnt - tl0), 128'd1);
      if (v == 0) begin
        lat_arm = 0;
        check(t_ready - t_valid == 4, "input_stall_cycles", 128'(t_ready - t_valid), 128'd4);
        check(t_out - t_valid == 6, "first_output_latency", 128'(t_out - t_valid), 128'd6);
      end
    end

    // Three back-to-back tokens under random downstream backpressure.
    ms_list[0] = 16'h0100;
    ms_list[1] = 16'h0040;
    ms_list[2] = 16'h1000;
    rand_rdy   = 1;
    tl0        = tlast_cnt;
    for (int t = 0; t < 3; t++) begin
      rs = model_rstd(ms_list[t]);
      for (int b = 0; b < BEATS; b++) begin
        x = {$urandom, $urandom, $urandom, $urandom};
        send_beat(x, (b == 0) ? ms_list[t] : 16'($urandom), model_beat(x, rs), b == BEATS - 1);
      end
    end
    S_AXIS_TVALID = 1'b0;
    wait_drain();
    rand_rdy = 0;
    check(tlast_cnt - tl0 == 3, "random_tlast_count", 128'(tlast_cnt - tl0), 128'd3);

    // Abort a token after 40 beats, then run a fresh token.
    rs = model_rstd(16'h0100);
    for (int b = 0; b < 40; b++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      send_beat(x, (b == 0) ? 16'h0100 : 16'($urandom), model_beat(x, rs), 1'b0);
    end
    arst          = 1'b1;
    S_AXIS_TVALID = 1'b0;
    @(posedge aclk);
    #1;
    exp_q.delete();
    reset_checks("midreset");
    @(posedge aclk);
    #1;
    arst = 1'b0;
    tl0  = tlast_cnt;
    for (int b = 0; b < BEATS; b++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      send_beat(x, (b == 0) ? 16'h0100 : 16'($urandom), model_beat(x, rs), b == BEATS - 1);
    end
    S_AXIS_TVALID = 1'b0;
    wait_drain();
    check(tlast_cnt - tl0 == 1, "post_reset_tlast_count", 128'(tlast_cnt - tl0), 128'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
